// File: rtl/bin_a_bcd.sv
// Iterative double-dabble binary-to-BCD converter with start/busy/valid handshake.
// Optional multiplexed 7-segment display driver enabled by the DISPLAY_MUX_EN macro.
module bin_a_bcd #(
    parameter int WIDTH    = 13,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 27000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  valid,
    output logic                  busy
`ifdef DISPLAY_MUX_EN
    ,
    output logic [DIGITS-1:0]     anodo,
    output logic [6:0]            segmentos
`endif
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Every WIDTH-bit value must fit in DIGITS decimal digits.
    if (((longint'(1) << WIDTH) - 1) > (pow10(DIGITS) - 1)) begin : g_bad_digits
        $error("bin_a_bcd: DIGITS too small for WIDTH");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan
        $error("bin_a_bcd: SCAN_DIV must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [SW-1:0]    scratch;
    logic [SW-1:0]    adj;
    logic [WIDTH-1:0] binreg;
    logic [CW-1:0]    cnt;

    // Handshake: start is level-sampled and accepted only in IDLE; busy is high
    // from acceptance until the result lands; valid pulses one cycle with bcd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Add-3 correction applied to each nibble before the shift.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch <= '0;
            binreg  <= '0;
            cnt     <= '0;
            bcd     <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        binreg  <= bin;
                        scratch <= '0;
                        cnt     <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    {scratch, binreg} <= {adj[SW-2:0], binreg, 1'b0};
                    cnt               <= cnt - CW'(1);
                end
                DONE: begin
                    bcd   <= scratch;
                    valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef DISPLAY_MUX_EN
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int KW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [KW-1:0] scan_cnt;
    logic [IW-1:0] idx;
    logic [IW-1:0] msd;
    logic [3:0]    digit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == KW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + KW'(1);
        end
    end

    // Highest non-zero digit; everything above it is blanked.
    always_comb begin
        msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) msd = IW'(i);
        end
    end

    always_comb begin
        digit = bcd[4*idx +: 4];
        anodo = ~(DIGITS'(1) << idx);
        case (digit)
            4'd0:    segmentos = 7'b1000000;
            4'd1:    segmentos = 7'b1111001;
            4'd2:    segmentos = 7'b0100100;
            4'd3:    segmentos = 7'b0110000;
            4'd4:    segmentos = 7'b0011001;
            4'd5:    segmentos = 7'b0010010;
            4'd6:    segmentos = 7'b0000010;
            4'd7:    segmentos = 7'b1111000;
            4'd8:    segmentos = 7'b0000000;
            4'd9:    segmentos = 7'b0010000;
            default: segmentos = 7'b1111111;
        endcase
        if (idx > msd) segmentos = 7'b1111111;
    end
`endif

endmodule

// File: tb/tb_bin_a_bcd.sv
// Directed self-checking bench for bin_a_bcd: latency, busy window, ignored
// starts, back-to-back retrigger, asynchronous abort, optional display scan.
module tb_bin_a_bcd;

    logic        clk;
    logic        rst;
    logic [12:0] bin;
    logic        start;
    logic [15:0] bcd;
    logic        valid;
    logic        busy;
`ifdef DISPLAY_MUX_EN
    logic [3:0]  anodo;
    logic [6:0]  segmentos;
`endif

    int checks = 0;
    int fails  = 0;

    bin_a_bcd #(.WIDTH(13), .DIGITS(4), .SCAN_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .bin   (bin),
        .start (start),
        .bcd   (bcd),
        .valid (valid),
        .busy  (busy)
`ifdef DISPLAY_MUX_EN
        ,
        .anodo     (anodo),
        .segmentos (segmentos)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse start for one edge, then watch 40 edges for valid pulses.
    task automatic do_conv(input logic [12:0] v, output logic [15:0] got,
                           output int lat, output int pulses);
        bin   = v;
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        got    = 16'hxxxx;
        lat    = -1;
        pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                if (pulses == 0) begin
                    lat = i;
                    got = bcd;
                end
                pulses++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bin = '0;
        #23;
        checks++; if (bcd !== 16'h0000) begin fails++; $display("FAIL reset_bcd got %h want 0000", bcd); end
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
`ifdef DISPLAY_MUX_EN
        checks++; if (anodo !== 4'b1110) begin fails++; $display("FAIL reset_anodo got %b want 1110", anodo); end
        checks++; if (segmentos !== 7'b1000000) begin fails++; $display("FAIL reset_seg got %b want 1000000", segmentos); end
`endif
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin fails++; $display("FAIL post_reset_idle busy %b valid %b want 0 0", busy, valid); end
    endtask

    task automatic test_basic();
        int busy_bad;
        bin = 13'd1998; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_bad = 0;
        if (busy !== 1'b1) busy_bad++;
        for (int i = 1; i <= 13; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b1 || valid !== 1'b0) busy_bad++;
        end
        checks++; if (busy_bad != 0) begin fails++; $display("FAIL basic_busy_window bad cycles %0d want 0", busy_bad); end
        @(posedge clk); #1;
        checks++; if (valid !== 1'b1) begin fails++; $display("FAIL basic_valid_at_14 got %b want 1", valid); end
        checks++; if (bcd !== 16'h1998) begin fails++; $display("FAIL basic_bcd got %h want 1998", bcd); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_end got %b want 0", busy); end
        @(posedge clk); #1;
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL basic_valid_one_cycle got %b want 0", valid); end
        checks++; if (bcd !== 16'h1998) begin fails++; $display("FAIL basic_bcd_hold got %h want 1998", bcd); end
    endtask

    task automatic test_sequence();
        logic [12:0] vals [3];
        logic [15:0] exps [3];
        logic [15:0] got;
        int lat, pulses;
        vals[0] = 13'd0;    exps[0] = 16'h0000;
        vals[1] = 13'd1100; exps[1] = 16'h1100;
        vals[2] = 13'd8191; exps[2] = 16'h8191;
        for (int k = 0; k < 3; k++) begin
            do_conv(vals[k], got, lat, pulses);
            checks++; if (got !== exps[k]) begin fails++; $display("FAIL seq_bcd[%0d] got %h want %h", k, got, exps[k]); end
            checks++; if (lat != 14) begin fails++; $display("FAIL seq_latency[%0d] got %0d want 14", k, lat); end
            checks++; if (pulses != 1) begin fails++; $display("FAIL seq_pulses[%0d] got %0d want 1", k, pulses); end
        end
    endtask

    task automatic test_ignore_start();
        int lat, pulses;
        logic [15:0] got;
        bin = 13'd500; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; pulses = 0; got = 16'hxxxx;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin bin = 13'd600; start = 1'b1; end
            @(posedge clk); #1;
            start = 1'b0;
            if (valid) begin
                if (pulses == 0) begin lat = i; got = bcd; end
                pulses++;
            end
        end
        checks++; if (got !== 16'h0500) begin fails++; $display("FAIL ignore_bcd got %h want 0500", got); end
        checks++; if (lat != 14) begin fails++; $display("FAIL ignore_latency got %0d want 14", lat); end
        checks++; if (pulses != 1) begin fails++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_back_to_back();
        int first, second;
        first = -1; second = -1;
        bin = 13'd999; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 40 && second < 0; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                if (first < 0) begin
                    first = i;
                    checks++; if (bcd !== 16'h0999) begin fails++; $display("FAIL b2b_bcd1 got %h want 0999", bcd); end
                end else begin
                    second = i;
                    start  = 1'b0;
                    checks++; if (bcd !== 16'h0999) begin fails++; $display("FAIL b2b_bcd2 got %h want 0999", bcd); end
                end
            end
        end
        start = 1'b0;
        checks++; if (first != 14) begin fails++; $display("FAIL b2b_first_latency got %0d want 14", first); end
        checks++; if (second - first != 15) begin fails++; $display("FAIL b2b_spacing got %0d want 15", second - first); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_no_third got busy %b want 0", busy); end
    endtask

    task automatic test_abort();
        int pulses, lat, p2;
        logic [15:0] got;
        bin = 13'd1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_before got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bcd !== 16'h0000) begin fails++; $display("FAIL abort_bcd got %h want 0000", bcd); end
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin fails++; $display("FAIL abort_flags busy %b valid %b want 0 0", busy, valid); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        checks++; if (pulses != 0) begin fails++; $display("FAIL abort_no_valid got %0d pulses want 0", pulses); end
        do_conv(13'd42, got, lat, p2);
        checks++; if (got !== 16'h0042) begin fails++; $display("FAIL abort_after_bcd got %h want 0042", got); end
        checks++; if (lat != 14 || p2 != 1) begin fails++; $display("FAIL abort_after_timing lat %0d pulses %0d want 14 1", lat, p2); end
    endtask

`ifdef DISPLAY_MUX_EN
    task automatic test_display();
        logic [3:0] prev;
        logic [3:0] an_exp [4];
        logic [6:0] sg_exp [4];
        int found;
        an_exp[0] = 4'b1110; sg_exp[0] = 7'b0100100;
        an_exp[1] = 4'b1101; sg_exp[1] = 7'b0011001;
        an_exp[2] = 4'b1011; sg_exp[2] = 7'b1111111;
        an_exp[3] = 4'b0111; sg_exp[3] = 7'b1111111;
        found = 0;
        prev  = anodo;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(posedge clk); #1;
            if (anodo === 4'b1110 && prev !== 4'b1110) found = 1;
            prev = anodo;
        end
        checks++; if (found != 1) begin fails++; $display("FAIL disp_sync got %0d want 1", found); end
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                if (s != 0 || c != 0) begin @(posedge clk); #1; end
                checks++;
                if (anodo !== an_exp[s] || segmentos !== sg_exp[s]) begin
                    fails++;
                    $display("FAIL disp_slot%0d_c%0d got %b/%b want %b/%b", s, c, anodo, segmentos, an_exp[s], sg_exp[s]);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_sequence();
        test_ignore_start();
        test_back_to_back();
        test_abort();
`ifdef DISPLAY_MUX_EN
        test_display();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bin_a_bcd.md
Name: bin_a_bcd

Overview:
Sequential binary-to-BCD converter (iterative double-dabble) on the result side of the arithmetic datapath. It takes the 13-bit sum produced by suma_aritmetica and decodes it into packed decimal digits for the display path. A start/busy/valid handshake lets the controlling FSM trigger one conversion per completed addition.

Parameters:
WIDTH, 13, binary input width.
DIGITS, 4, number of BCD output digits. Must satisfy 2^WIDTH-1 <= 10^DIGITS-1. Elaboration error otherwise.
SCAN_DIV, 27000, clk cycles per display digit slot (about 1 kHz at 27 MHz). Used only with DISPLAY_MUX_EN.

Ports:
clk  in  1  system clock, 27 MHz
rst  in  1  asynchronous reset, active-high
bin  in  WIDTH  unsigned binary value, sampled only on accepted start
start  in  1  conversion request, level-sampled on rising clk
bcd  out  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0]
valid  out  1  one-cycle pulse when bcd has just updated
busy  out  1  conversion in progress

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - Reset is asynchronous and active-high on rst.
  - Reset forces state IDLE, bcd=0, valid=0, busy=0, and clears the shift register and counter.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0.
  - If start=1 at edge N: latch bin into the binary shift register, clear the BCD scratch, set counter=WIDTH, go to SHIFT.
- SHIFT, one iteration per clock:
  - First, every scratch nibble >=5 gets +3 (4-bit add, no carry out of the nibble).
  - Then shift {scratch, binreg} left by 1.
  - Decrement the counter. The iteration that takes the counter to 0 moves the FSM to DONE.
- DONE:
  - Copy scratch to bcd, pulse valid=1 for exactly one cycle, return to IDLE.
- Latency:
  - start sampled at edge N. The WIDTH shifts happen on edges N+1..N+WIDTH.
  - bcd and valid update at edge N+WIDTH+1, which is 14 cycles with defaults.
- busy = (state != IDLE). It is high after edges N..N+WIDTH and low after edge N+WIDTH+1.
- start while busy=1 is ignored; no queueing.
- bin changes after acceptance have no effect on the current conversion.
- start=1 in the cycle valid is high is accepted, since the FSM is in IDLE. Back-to-back conversions therefore run every WIDTH+2 cycles.
- bcd holds its last result until the next DONE. It never shows intermediate scratch values.
- start held high continuously retriggers one conversion per IDLE visit.
- Reset asserted mid-conversion aborts immediately: no valid pulse, bcd=0.

Optional Feature:
Macro: DISPLAY_MUX_EN.
- Defined:
  - Adds output anodo [DIGITS] (active-low one-hot digit enable) and output segmentos [7] (active-low, order gfedcba).
  - A free-running counter wraps at SCAN_DIV-1 and advances digit index 0..DIGITS-1 cyclically.
  - segmentos shows the 7-segment pattern of bcd digit [index].
  - Leading-zero blanking applies: a digit above the most significant non-zero digit drives all segments off. Digit 0 is always shown.
  - Reset values: anodo all 1 except digit 0 low, segmentos = pattern for 0, index=0, scan counter=0.
  - The display always reads the registered bcd, never scratch.
- Undefined:
  - The ports, scan counter and decoder are absent. The converter behaviour is identical either way.

Test Plan:
- Reset, then bin=1998 with start pulsed 1 cycle -> busy high 14 cycles; bcd=16'h1998 with valid=1 exactly 14 cycles after the start edge; valid low the next cycle.
- Successive conversions of bin=0, 1100, 8191 (WIDTH max) -> bcd=16'h0000, 16'h1100 and 16'h8191 respectively, one valid pulse each.
- Start bin=500, then at cycle 5 set bin=600 and pulse start again -> second start ignored; result 16'h0500; single valid pulse.
- Start bin=999 and hold start high through valid -> a new conversion is accepted in the valid cycle; next valid exactly 15 cycles later, bcd=16'h0999.
- Start bin=1234, then assert rst asynchronously at cycle 7 (between clock edges) -> outputs 0 immediately; no valid pulse. After release, bin=42 converts to 16'h0042.
- With DISPLAY_MUX_EN and SCAN_DIV=4, bin=42 -> anodo cycles 1110, 1101, 1011, 0111 every 4 clks; segmentos shows 2 (0100100), then 4 (0011001), then blank (1111111), then blank.
